// File: rtl/vga_pkg.sv
// Shared XGA (1024x768 @ 60 Hz) timing constants and small helpers for the
// VGA timing generator.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned OUT_W = 12;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned CNT_LIMIT = (1 << CNT_W) - 1;

    localparam int unsigned XGA_H_ACTIVE = 1024;
    localparam int unsigned XGA_H_FP     = 24;
    localparam int unsigned XGA_H_SYNC   = 136;
    localparam int unsigned XGA_H_BP     = 160;
    localparam int unsigned XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

    localparam int unsigned XGA_V_ACTIVE = 768;
    localparam int unsigned XGA_V_FP     = 3;
    localparam int unsigned XGA_V_SYNC   = 6;
    localparam int unsigned XGA_V_BP     = 29;
    localparam int unsigned XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic sync;
        logic blnk;
    } axis_flags_t;

    // Sync window is [active+fp, active+fp+sync); blanking starts at active.
    function automatic axis_flags_t axis_flags(
        input cnt_t cnt,
        input cnt_t blnk_start,
        input cnt_t sync_start,
        input cnt_t sync_end
    );
        axis_flags_t f;
        f.blnk = (cnt >= blnk_start);
        f.sync = (cnt >= sync_start) && (cnt < sync_end);
        return f;
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: wrap-around counter with enable and carry-out; exposes the
// next-state value so callers can register derived flags with zero skew.
module mod_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL = XGA_H_TOTAL,
    parameter int unsigned W     = CNT_W
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    always_comb begin
        carry      = en && (count == LAST);
        count_next = count;
        if (rst) begin
            count_next = '0;
        end else if (carry) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        count <= count_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: registered h/v counts, sync and blank flags.
// Optional frame_start/frame_cnt logic is enabled by VGA_TIMING_FRAME_TICK_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
    parameter int unsigned H_FP     = XGA_H_FP,
    parameter int unsigned H_SYNC   = XGA_H_SYNC,
    parameter int unsigned H_BP     = XGA_H_BP,
    parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
    parameter int unsigned V_FP     = XGA_V_FP,
    parameter int unsigned V_SYNC   = XGA_V_SYNC,
    parameter int unsigned V_BP     = XGA_V_BP
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   en,
    output logic [OUT_W-1:0]       hcount_out,
    output logic                   hsync_out,
    output logic                   hblnk_out,
    output logic [OUT_W-1:0]       vcount_out,
    output logic                   vsync_out,
    output logic                   vblnk_out,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > CNT_LIMIT) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, CNT_LIMIT);
    end
    if (V_TOTAL > CNT_LIMIT) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, CNT_LIMIT);
    end

    localparam cnt_t H_BLNK_START = CNT_W'(H_ACTIVE);
    localparam cnt_t H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_BLNK_START = CNT_W'(V_ACTIVE);
    localparam cnt_t V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t        h_count;
    cnt_t        h_next;
    logic        h_carry;
    cnt_t        v_count;
    cnt_t        v_next;
    logic        v_carry;
    axis_flags_t h_flags_next;
    axis_flags_t v_flags_next;
    axis_flags_t h_flags;
    axis_flags_t v_flags;

    mod_counter #(
        .TOTAL (H_TOTAL),
        .W     (CNT_W)
    ) u_h_counter (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .count      (h_count),
        .count_next (h_next),
        .carry      (h_carry)
    );

    // The vertical counter steps only on the horizontal wrap.
    mod_counter #(
        .TOTAL (V_TOTAL),
        .W     (CNT_W)
    ) u_v_counter (
        .pclk       (pclk),
        .rst        (rst),
        .en         (h_carry),
        .count      (v_count),
        .count_next (v_next),
        .carry      (v_carry)
    );

    // Flags are derived from the counters' next values so they land in the
    // same output cycle as the counts they describe.
    always_comb begin
        h_flags_next = axis_flags(h_next, H_BLNK_START, H_SYNC_START, H_SYNC_END);
        v_flags_next = axis_flags(v_next, V_BLNK_START, V_SYNC_START, V_SYNC_END);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            h_flags <= '0;
            v_flags <= '0;
        end else begin
            h_flags <= h_flags_next;
            v_flags <= v_flags_next;
        end
    end

    always_comb begin
        hcount_out = {1'b0, h_count};
        vcount_out = {1'b0, v_count};
        hsync_out  = h_flags.sync;
        hblnk_out  = h_flags.blnk;
        vsync_out  = v_flags.sync;
        vblnk_out  = v_flags.blnk;
    end

`ifdef VGA_TIMING_FRAME_TICK_EN
    logic                   frame_start_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    // v_carry already implies en and the horizontal wrap: (last, last) -> (0, 0).
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= v_carry;
            if (v_carry) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        frame_start = frame_start_q;
        frame_cnt   = frame_cnt_q;
    end
`else
    logic frame_wrap_unused;

    always_comb begin
        frame_wrap_unused = v_carry;
        frame_start       = 1'b0;
        frame_cnt         = '0;
    end
`endif

endmodule
